// File: rtl/tracker_pkg.sv
// Shared tracker types: the 16-bit note row, instrument/effect codes and the
// sequencer FSM state encoding.
package tracker_pkg;

    typedef struct packed {
        logic [2:0] tone;
        logic [2:0] octave;
        logic [1:0] instrument;
        logic [4:0] volume;
        logic [2:0] effect;
    } note_tp;

    localparam logic [1:0] INSTR_SQUARE = 2'd0;
    localparam logic [1:0] INSTR_SAW    = 2'd1;
    localparam logic [1:0] INSTR_TRI    = 2'd2;
    localparam logic [1:0] INSTR_NOISE  = 2'd3;

    localparam logic [2:0] EFF_NONE     = 3'd0;
    localparam logic [2:0] EFF_ARP      = 3'd1;
    localparam logic [2:0] EFF_SLIDE_UP = 3'd2;
    localparam logic [2:0] EFF_SLIDE_DN = 3'd3;
    localparam logic [2:0] EFF_VIBRATO  = 3'd4;
    localparam logic [2:0] EFF_TREMOLO  = 3'd5;
    localparam logic [2:0] EFF_CUT      = 3'd6;
    localparam logic [2:0] EFF_RETRIG   = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/tracker_sequencer_pattern_ram.sv
// Pattern storage: DEPTH x note_tp, one write port and one synchronous read port.
// Read-during-write to the same address returns the previously stored row.
module pattern_ram
    import tracker_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int ADDRLEN = $clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_wr_en,
    input  logic [ADDRLEN-1:0] i_wr_addr,
    input  note_tp             i_wr_data,
    input  logic               i_rd_en,
    input  logic [ADDRLEN-1:0] i_rd_addr,
    output note_tp             o_rd_data
);

    note_tp r_mem [DEPTH];
    note_tp r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/tracker_sequencer.sv
// Pattern player: steps through stored note rows, one row per tempo period,
// with optional looping and end-of-pattern signalling.
module tracker_sequencer
    import tracker_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int ADDRLEN = $clog2(DEPTH),
    parameter int LENLEN  = $clog2(DEPTH) + 1,
    parameter int TKLEN   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [ADDRLEN-1:0] wr_addr,
    input  note_tp             wr_data,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    input  logic [LENLEN-1:0]  length,
    input  logic [TKLEN-1:0]   ticks_per_row,
    output note_tp             note,
    output logic               note_valid,
    output logic [ADDRLEN-1:0] row,
    output logic               playing,
    output logic               done
);

    seq_state_t         r_state;
    logic [TKLEN-1:0]   r_tick;
    logic [TKLEN-1:0]   r_period;
    logic [LENLEN-1:0]  r_len;
    logic               r_loop;
    logic [ADDRLEN-1:0] r_next_row;
    logic [ADDRLEN-1:0] r_row;
    note_tp             r_note;
    logic               r_note_valid;
    logic               r_playing;
    logic               r_done;

    logic [LENLEN-1:0]  w_len_clamped;
    logic [TKLEN-1:0]   w_period;
    logic               w_start_ok;
    logic               w_tick_end;
    logic               w_last_row;
    logic [ADDRLEN-1:0] w_next_after;
    logic               w_rd_en;
    note_tp             w_rd_data;

    assign w_len_clamped = (length > LENLEN'(DEPTH)) ? LENLEN'(DEPTH) : length;
    assign w_period      = (ticks_per_row < TKLEN'(2)) ? TKLEN'(2) : ticks_per_row;
    assign w_start_ok    = start && !stop && (length != '0);
    assign w_tick_end    = (r_tick == r_period - TKLEN'(1));
    assign w_last_row    = (LENLEN'(r_row) == r_len - LENLEN'(1));
    assign w_next_after  = (LENLEN'(r_next_row) == r_len - LENLEN'(1)) ?
                           '0 : r_next_row + ADDRLEN'(1);

    // The RAM is read one cycle before each load edge so rd_data is ready
    // exactly when the row is registered onto note.
    assign w_rd_en = ((r_state == FETCH) && (r_tick == '0)) ||
                     ((r_state == HOLD) && (r_tick == r_period - TKLEN'(2)));

    pattern_ram #(
        .DEPTH   (DEPTH),
        .ADDRLEN (ADDRLEN)
    ) u_pattern_ram (
        .i_clk     (clk),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_next_row),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_tick       <= '0;
            r_period     <= '0;
            r_len        <= '0;
            r_loop       <= 1'b0;
            r_next_row   <= '0;
            r_row        <= '0;
            r_note       <= '0;
            r_note_valid <= 1'b0;
            r_playing    <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_note_valid <= 1'b0;
            r_done       <= 1'b0;
            if (stop) begin
                r_state   <= IDLE;
                r_tick    <= '0;
                r_row     <= '0;
                r_note    <= '0;
                r_playing <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_start_ok) begin
                            r_state    <= FETCH;
                            r_playing  <= 1'b1;
                            r_len      <= w_len_clamped;
                            r_period   <= w_period;
                            r_loop     <= loop_en;
                            r_next_row <= '0;
                            r_tick     <= '0;
                        end
                    end
                    FETCH: begin
                        if (r_tick == TKLEN'(1)) begin
                            r_state      <= HOLD;
                            r_note       <= w_rd_data;
                            r_note_valid <= 1'b1;
                            r_row        <= r_next_row;
                            r_next_row   <= w_next_after;
                            r_tick       <= '0;
                        end else begin
                            r_tick <= r_tick + TKLEN'(1);
                        end
                    end
                    HOLD: begin
                        if (!w_tick_end) begin
                            r_tick <= r_tick + TKLEN'(1);
                        end else if (w_last_row && !r_loop) begin
                            r_state   <= IDLE;
                            r_playing <= 1'b0;
                            r_done    <= 1'b1;
                            r_note    <= '0;
                            r_row     <= '0;
                            r_tick    <= '0;
                        end else begin
                            // r_next_row already wrapped to 0 after the last row.
                            r_note       <= w_rd_data;
                            r_note_valid <= 1'b1;
                            r_row        <= r_next_row;
                            r_next_row   <= w_next_after;
                            r_tick       <= '0;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign note       = r_note;
    assign note_valid = r_note_valid;
    assign row        = r_row;
    assign playing    = r_playing;
    assign done       = r_done;

endmodule

// File: tb/tb_tracker_sequencer.sv
// Directed bench for tracker_sequencer: playback timing, looping, stop,
// edge controls, length clamp, write during playback and async reset.
module tb_tracker_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic        stop;
    logic        loop_en;
    logic [6:0]  length;
    logic [15:0] ticks_per_row;
    logic [15:0] note;
    logic        note_valid;
    logic [5:0]  row;
    logic        playing;
    logic        done;

    logic [15:0] m_mem [64];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    tracker_sequencer #(
        .DEPTH (64),
        .TKLEN (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .start         (start),
        .stop          (stop),
        .loop_en       (loop_en),
        .length        (length),
        .ticks_per_row (ticks_per_row),
        .note          (note),
        .note_valid    (note_valid),
        .row           (row),
        .playing       (playing),
        .done          (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_row(input logic [5:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        m_mem[a] = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".playing"}, 32'(playing), 32'd0);
        check({tag, ".valid"},   32'(note_valid), 32'd0);
        check({tag, ".note"},    32'(note), 32'd0);
        check({tag, ".row"},     32'(row), 32'd0);
        check({tag, ".done"},    32'(done), 32'd0);
    endtask

    // Starts playback (length/ticks/loop already set) and checks every output
    // in every cycle c after the accepting edge E0. Controls are scrambled after
    // acceptance; an optional write is injected at cycle wr_cyc.
    task automatic run_play(input string tag, input int len, input int p, input bit lp,
                            input int ncyc, input int wr_cyc,
                            input logic [5:0] wa, input logic [15:0] wd);
        logic [15:0] exp_note;
        logic [5:0]  exp_row;
        bit          exp_v, exp_d, exp_p;
        int          k;
        exp_note = '0;
        exp_row  = '0;
        exp_p    = 1'b1;
        start = 1'b1;
        step();
        start         = 1'b0;
        length        = 7'd1;
        ticks_per_row = 16'd9;
        loop_en       = ~lp;
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) step();
            wr_en = 1'b0;
            exp_v = 1'b0;
            exp_d = 1'b0;
            if (c >= 2 && (c - 2) % p == 0) begin
                k = (c - 2) / p;
                if (!lp && k == len) begin
                    exp_d    = 1'b1;
                    exp_p    = 1'b0;
                    exp_note = '0;
                    exp_row  = '0;
                end else if (lp || k < len) begin
                    exp_v    = 1'b1;
                    exp_row  = 6'(k % len);
                    exp_note = m_mem[k % len];
                end
            end
            check($sformatf("%s.valid@%0d", tag, c),   32'(note_valid), 32'(exp_v));
            check($sformatf("%s.done@%0d", tag, c),    32'(done),       32'(exp_d));
            check($sformatf("%s.playing@%0d", tag, c), 32'(playing),    32'(exp_p));
            check($sformatf("%s.note@%0d", tag, c),    32'(note),       32'(exp_note));
            check($sformatf("%s.row@%0d", tag, c),     32'(row),        32'(exp_row));
            if (c == wr_cyc) begin
                wr_en   = 1'b1;
                wr_addr = wa;
                wr_data = wd;
                m_mem[wa] = wd;
            end
        end
    endtask

    task automatic setup(input int len, input int tpr, input bit lp);
        length        = 7'(len);
        ticks_per_row = 16'(tpr);
        loop_en       = lp;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; loop_en = 1'b0; length = '0; ticks_per_row = '0;
        step();
        step();
        check_idle("reset");
        rst = 1'b0;
        step();
        check_idle("post_reset");

        write_row(6'd0, 16'h1111);
        write_row(6'd1, 16'h2222);
        write_row(6'd2, 16'h3333);
        write_row(6'd3, 16'h4444);

        // Basic: valid at 2,7,12,17; done at 22.
        setup(4, 5, 1'b0);
        run_play("basic", 4, 5, 1'b0, 25, -1, '0, '0);

        // Looping rows 0,1,0,1,0 at 2,5,8,11,14, then stop.
        setup(2, 3, 1'b1);
        run_play("loop", 2, 3, 1'b1, 16, -1, '0, '0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_idle("loop_stop");

        setup(3, 0, 1'b0);
        run_play("tpr0", 3, 2, 1'b0, 10, -1, '0, '0);
        setup(3, 1, 1'b0);
        run_play("tpr1", 3, 2, 1'b0, 10, -1, '0, '0);

        // Stop while row 2 is held, then replay from row 0.
        setup(4, 5, 1'b0);
        run_play("pre_stop", 4, 5, 1'b0, 14, -1, '0, '0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_idle("stop");
        step();
        check_idle("stop_hold");
        setup(4, 5, 1'b0);
        run_play("restart", 4, 5, 1'b0, 25, -1, '0, '0);

        setup(4, 5, 1'b0);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check_idle("start_stop0");
        step();
        check_idle("start_stop1");

        setup(0, 5, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        check_idle("len0_0");
        step();
        check_idle("len0_1");
        step();
        check_idle("len0_2");

        // Length 100 clamps to 64 rows.
        for (int i = 0; i < 64; i++) begin
            write_row(6'(i), {8'(i), ~8'(i)});
        end
        setup(100, 2, 1'b0);
        run_play("clamp", 64, 2, 1'b0, 132, -1, '0, '0);

        // Row 3 rewritten while row 1 plays.
        setup(4, 5, 1'b0);
        run_play("wr_play", 4, 5, 1'b0, 25, 8, 6'd3, 16'hABCD);
        check("wr_play.model", 32'(m_mem[3]), 32'h0000ABCD);

        // Async reset between edges while row 1 is held.
        setup(2, 3, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 6; c++) step();
        check("arst.pre_playing", 32'(playing), 32'd1);
        check("arst.pre_row", 32'(row), 32'd1);
        check("arst.pre_note", 32'(note), 32'(m_mem[1]));
        #3;
        rst = 1'b1;
        #1;
        check_idle("arst");
        step();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check_idle($sformatf("arst_after%0d", c));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
